if_fetch_unit: RTL and testbench

//  Instruction-fetch stage master for the pipelined LEGv8 core. It owns the PC and drives the

---
 rtl/if_fetch_unit.sv | 118 +++++++++++
 tb/tb_if_fetch_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: LEGv8 instruction-fetch stage (PC, ROM port, IF/ID register, halt detection)
// Optional IF_PERF_CNT_EN adds saturating fetch_cnt / redirect_cnt outputs.
module if_fetch_unit #(
    parameter int          N       = 64,
    parameter int          AW      = 7,
    parameter logic [31:0] HALT_OP = 32'hb400001f
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall_f,
    input  logic          pcsrc_m,
    input  logic [N-1:0]  branch_tgt_m,
    output logic [AW-1:0] imem_addr,
    output logic          imem_en,
    input  logic [31:0]   imem_q,
    output logic [31:0]   instr_d,
    output logic [N-1:0]  pc_d,
    output logic          valid_d,
    output logic          halted,
    output logic          misalign_err
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]   fetch_cnt,
    output logic [15:0]   redirect_cnt
`endif
);
    typedef enum logic [1:0] {BOOT, RUN, HPEND, HALT} state_t;
    state_t state, state_n;
    logic [N-1:0] pc, pc_n, halt_pc, halt_pc_n, pc_d_n;
    logic [31:0] instr_n;
    logic valid_n, mis_n, fetch, redir;
    assign imem_addr = pc[AW+1:2];
    assign imem_en = state == RUN;
    assign halted = state == HALT;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BOOT;
            pc <= '0;
            halt_pc <= '0;
            instr_d <= '0;
            pc_d <= '0;
            valid_d <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            state <= state_n;
            pc <= pc_n;
            halt_pc <= halt_pc_n;
            instr_d <= instr_n;
            pc_d <= pc_d_n;
            valid_d <= valid_n;
            misalign_err <= mis_n;
        end
    end
    always_comb begin
        state_n = state;
        pc_n = pc;
        halt_pc_n = halt_pc;
        instr_n = instr_d;
        pc_d_n = pc_d;
        valid_n = valid_d;
        fetch = 1'b0;
        redir = 1'b0;
        case (state)
            BOOT: begin
                state_n = RUN;
                instr_n = '0;
                valid_n = 1'b0;
            end
            RUN: begin
                if (pcsrc_m) begin
                    redir = 1'b1;
                    pc_n = branch_tgt_m;
                    instr_n = '0;
                    valid_n = 1'b0;
                end else if (!stall_f) begin
                    fetch = 1'b1;
                    instr_n = imem_q;
                    pc_d_n = pc;
                    valid_n = 1'b1;
                    pc_n = pc + N'(4);
                    if (imem_q == HALT_OP) begin
                        halt_pc_n = pc;
                        state_n = HPEND;
                    end
                end
            end
            HPEND: begin
                // A taken branch at halt_pc is the halt CBZ itself; any other target means it was squashed.
                if (pcsrc_m) begin
                    redir = 1'b1;
                    instr_n = '0;
                    valid_n = 1'b0;
                    state_n = branch_tgt_m == halt_pc ? HALT : RUN;
                    pc_n = branch_tgt_m == halt_pc ? pc : branch_tgt_m;
                end else if (!stall_f) begin
                    instr_n = '0;
                    valid_n = 1'b0;
                end
            end
            default: begin
                instr_n = '0;
                valid_n = 1'b0;
            end
        endcase
        mis_n = misalign_err | (redir && branch_tgt_m[1:0] != 2'b00);
    end
`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt <= '0;
            redirect_cnt <= '0;
        end else begin
            fetch_cnt <= fetch && !(&fetch_cnt) ? fetch_cnt + 32'd1 : fetch_cnt;
            redirect_cnt <= redir && !(&redirect_cnt) ? redirect_cnt + 16'd1 : redirect_cnt;
        end
    end
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed self-checking bench for if_fetch_unit with a combinational ROM model.
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        reset, stall_f, pcsrc_m;
    logic [63:0] branch_tgt_m;
    logic [6:0]  imem_addr;
    logic        imem_en;
    logic [31:0] imem_q, instr_d;
    logic [63:0] pc_d;
    logic        valid_d, halted, misalign_err;
    logic [31:0] rom [128];
    int          compared = 0;
    int          mismatched = 0;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [15:0] redirect_cnt;
`endif

    if_fetch_unit dut (
        .clk(clk), .reset(reset), .stall_f(stall_f), .pcsrc_m(pcsrc_m),
        .branch_tgt_m(branch_tgt_m), .imem_addr(imem_addr), .imem_en(imem_en),
        .imem_q(imem_q), .instr_d(instr_d), .pc_d(pc_d), .valid_d(valid_d),
        .halted(halted), .misalign_err(misalign_err)
`ifdef IF_PERF_CNT_EN
        , .fetch_cnt(fetch_cnt), .redirect_cnt(redirect_cnt)
`endif
    );

    always #5 clk = ~clk;
    assign imem_q = imem_en ? rom[imem_addr] : 32'h0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"}, 64'(valid_d), 64'd0);
        check({tag, "_instr"}, 64'(instr_d), 64'd0);
        check({tag, "_pcd"}, pc_d, 64'd0);
        check({tag, "_halted"}, 64'(halted), 64'd0);
        check({tag, "_mis"}, 64'(misalign_err), 64'd0);
        check({tag, "_addr"}, 64'(imem_addr), 64'd0);
        check({tag, "_en"}, 64'(imem_en), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = 32'h0;
        rom[0] = 32'hf8000001;
        rom[1] = 32'hf8008002;
        rom[2] = 32'hf8000203;
        rom[3] = 32'h8b050083;
        rom[52] = 32'hb400001f;
        reset = 1'b1; stall_f = 1'b0; pcsrc_m = 1'b0; branch_tgt_m = '0;
        tick();
        tick();
        check_reset_vals("rst");
`ifdef IF_PERF_CNT_EN
        check("rst_fcnt", 64'(fetch_cnt), 64'd0);
        check("rst_rcnt", 64'(redirect_cnt), 64'd0);
`endif
        reset = 1'b0;
        tick();
        check("boot_valid", 64'(valid_d), 64'd0);
        check("boot_en", 64'(imem_en), 64'd1);
        tick();
        check("f0_instr", 64'(instr_d), 64'hf8000001);
        check("f0_pcd", pc_d, 64'h0);
        check("f0_valid", 64'(valid_d), 64'd1);
        tick();
        check("f1_instr", 64'(instr_d), 64'hf8008002);
        check("f1_pcd", pc_d, 64'h4);
        // two stall cycles
        stall_f = 1'b1;
        tick();
        check("st1_instr", 64'(instr_d), 64'hf8008002);
        check("st1_addr", 64'(imem_addr), 64'd2);
        tick();
        check("st2_instr", 64'(instr_d), 64'hf8008002);
        check("st2_addr", 64'(imem_addr), 64'd2);
        check("st2_pcd", pc_d, 64'h4);
        stall_f = 1'b0;
        tick();
        check("f2_pcd", pc_d, 64'h8);
        check("f2_instr", 64'(instr_d), 64'hf8000203);
        // redirect wins over stall
        pcsrc_m = 1'b1; stall_f = 1'b1; branch_tgt_m = 64'h40;
        tick();
        check("rd_valid", 64'(valid_d), 64'd0);
        check("rd_instr", 64'(instr_d), 64'd0);
        check("rd_addr", 64'(imem_addr), 64'd16);
        pcsrc_m = 1'b0; stall_f = 1'b0;
        tick();
        check("rd_pcd", pc_d, 64'h40);
        check("rd_valid2", 64'(valid_d), 64'd1);
        tick();
        check("f44_pcd", pc_d, 64'h44);
`ifdef IF_PERF_CNT_EN
        check("fcnt5", 64'(fetch_cnt), 64'd5);
        check("rcnt1", 64'(redirect_cnt), 64'd1);
`endif
        // fetch the halt word, then squash it with an older branch
        pcsrc_m = 1'b1; branch_tgt_m = 64'hd0;
        tick();
        check("h1_addr", 64'(imem_addr), 64'd52);
        pcsrc_m = 1'b0;
        tick();
        check("h1_pcd", pc_d, 64'hd0);
        check("h1_instr", 64'(instr_d), 64'hb400001f);
        check("h1_en", 64'(imem_en), 64'd0);
        check("h1_halted", 64'(halted), 64'd0);
        tick();
        check("hp_bubble", 64'(valid_d), 64'd0);
        check("hp_addr", 64'(imem_addr), 64'd53);
        pcsrc_m = 1'b1; branch_tgt_m = 64'h20;
        tick();
        check("sq_valid", 64'(valid_d), 64'd0);
        check("sq_en", 64'(imem_en), 64'd1);
        check("sq_addr", 64'(imem_addr), 64'd8);
        pcsrc_m = 1'b0;
        tick();
        check("sq_pcd", pc_d, 64'h20);
        check("sq_halted", 64'(halted), 64'd0);
        check("sq_mis", 64'(misalign_err), 64'd0);
        // misaligned redirect
        pcsrc_m = 1'b1; branch_tgt_m = 64'h22;
        tick();
        check("mis_set", 64'(misalign_err), 64'd1);
        check("mis_addr", 64'(imem_addr), 64'd8);
        pcsrc_m = 1'b0;
        tick();
        check("mis_pcd", pc_d, 64'h22);
        tick();
        check("mis_sticky", 64'(misalign_err), 64'd1);
        check("mis_pcd2", pc_d, 64'h26);
        // stall coinciding with the halt-word fetch delays its capture
        pcsrc_m = 1'b1; branch_tgt_m = 64'hd0;
        tick();
        pcsrc_m = 1'b0; stall_f = 1'b1;
        tick();
        check("hs_valid", 64'(valid_d), 64'd0);
        check("hs_en", 64'(imem_en), 64'd1);
        stall_f = 1'b0;
        tick();
        check("hs_pcd", pc_d, 64'hd0);
        check("hs_en2", 64'(imem_en), 64'd0);
        // halt CBZ taken
        pcsrc_m = 1'b1; branch_tgt_m = 64'hd0;
        tick();
        check("halt_halted", 64'(halted), 64'd1);
        check("halt_en", 64'(imem_en), 64'd0);
        check("halt_valid", 64'(valid_d), 64'd0);
        branch_tgt_m = 64'h40; stall_f = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_halted", 64'(halted), 64'd1);
            check("hold_valid", 64'(valid_d), 64'd0);
            check("hold_en", 64'(imem_en), 64'd0);
        end
        check("hold_mis", 64'(misalign_err), 64'd1);
        // reset out of HALT
        reset = 1'b1; pcsrc_m = 1'b0; stall_f = 1'b0;
        tick();
        check_reset_vals("rst2");
`ifdef IF_PERF_CNT_EN
        check("rst2_fcnt", 64'(fetch_cnt), 64'd0);
        check("rst2_rcnt", 64'(redirect_cnt), 64'd0);
`endif
        reset = 1'b0;
        tick();
        check("boot2_valid", 64'(valid_d), 64'd0);
        tick();
        check("r2_instr", 64'(instr_d), 64'hf8000001);
        check("r2_pcd", pc_d, 64'h0);
        check("r2_valid", 64'(valid_d), 64'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
